// File: rtl/ctrl_fetch_seq.sv
// Fetch sequencer: owns the PC, picks increment / hold / redirect / halt each
// cycle, and keeps a small circular return-address stack for call/return.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_BOOT  | first cycle after reset, PC held at RESET_VEC, fetch not valid
// ST_RUN   | normal fetch: redirect > halt > stall > increment
// ST_FLUSH | one bubble cycle after a redirect, PC holds the target
// ST_HALT  | parked on HALT until resume, all pipeline inputs ignored
module ctrl_fetch_seq #(
  parameter int unsigned PROG_CTR_WID = 10,
  parameter logic [PROG_CTR_WID-1:0] RESET_VEC = '0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_hz,
  input  logic                    branch_taken_EX,
  input  logic [PROG_CTR_WID-1:0] nxt_prog_ctr_EX,
  input  logic                    call_EX,
  input  logic                    ret_EX,
  input  logic [PROG_CTR_WID-1:0] link_addr_EX,
  input  logic                    halt_ID,
  input  logic                    resume,
  output logic [PROG_CTR_WID-1:0] prog_ctr,
  output logic                    instr_valid_IF,
  output logic                    flush_ID_EX,
  output logic                    halted,
  output logic                    ras_err
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH, ST_HALT} state_t;

  state_t                  state_q, state_d;
  logic [PROG_CTR_WID-1:0] prog_ctr_q, prog_ctr_d;
  logic                    valid_q, valid_d;
  logic                    flush_q, flush_d;
  logic                    halted_q, halted_d;
  logic                    ras_err_q, ras_err_d;
  logic [PROG_CTR_WID-1:0] ras_q [RAS_DEPTH];
  logic [PROG_CTR_WID-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]           ras_ptr_q, ras_ptr_d;
  logic [CW-1:0]           ras_cnt_q, ras_cnt_d;

  logic [PROG_CTR_WID-1:0] target;
  logic [PW-1:0]           ras_top;
  logic                    ras_empty;
  logic                    ras_full;

  // ras_ptr_q points at the next free slot; the top entry sits one below it.
  assign ras_top   = ras_ptr_q - PW'(1);
  assign ras_empty = (ras_cnt_q == '0);
  assign ras_full  = (ras_cnt_q == CW'(RAS_DEPTH));

  // Next-state, PC selection and RAS push/pop.
  always_comb begin
    state_d    = state_q;
    prog_ctr_d = prog_ctr_q;
    valid_d    = valid_q;
    flush_d    = 1'b0;
    halted_d   = halted_q;
    ras_err_d  = ras_err_q;
    ras_d      = ras_q;
    ras_ptr_d  = ras_ptr_q;
    ras_cnt_d  = ras_cnt_q;
    target     = nxt_prog_ctr_EX;
    case (state_q)
      ST_BOOT: begin
        valid_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken_EX || ret_EX) begin
          if (ret_EX) begin
            // Return wins over a simultaneous call; empty stack falls back to EX target.
            if (!ras_empty) begin
              target    = ras_q[ras_top];
              ras_ptr_d = ras_top;
              ras_cnt_d = ras_cnt_q - CW'(1);
            end else begin
              ras_err_d = 1'b1;
            end
          end else if (call_EX) begin
            // Full stack overwrites the oldest entry; depth count saturates.
            ras_d[ras_ptr_q] = link_addr_EX;
            ras_ptr_d        = ras_ptr_q + PW'(1);
            if (ras_full) ras_err_d = 1'b1;
            else          ras_cnt_d = ras_cnt_q + CW'(1);
          end
          prog_ctr_d = target;
          flush_d    = 1'b1;
          valid_d    = 1'b0;
          state_d    = ST_FLUSH;
        end else if (halt_ID) begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (stall_hz) begin
          valid_d = 1'b1;
        end else begin
          prog_ctr_d = prog_ctr_q + PROG_CTR_WID'(1);
          valid_d    = 1'b1;
        end
      end
      ST_FLUSH: begin
        valid_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_HALT: begin
        if (resume) begin
          prog_ctr_d = prog_ctr_q + PROG_CTR_WID'(1);
          halted_d   = 1'b0;
          valid_d    = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      prog_ctr_q <= RESET_VEC;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      halted_q   <= 1'b0;
      ras_err_q  <= 1'b0;
      ras_ptr_q  <= '0;
      ras_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prog_ctr_q <= prog_ctr_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      halted_q   <= halted_d;
      ras_err_q  <= ras_err_d;
      ras_ptr_q  <= ras_ptr_d;
      ras_cnt_q  <= ras_cnt_d;
    end
  end

  // Stack storage needs no reset: entries are only read when the count says they are valid.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign prog_ctr       = prog_ctr_q;
  assign instr_valid_IF = valid_q;
  assign flush_ID_EX    = flush_q;
  assign halted         = halted_q;
  assign ras_err        = ras_err_q;

endmodule
